// File: rtl/verinject_pkg.sv
// Shared types and constants for the fault-injection sequencer.
package verinject_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // "bit" is a keyword, so the target index field is named bit_index
    typedef struct packed {
        logic [31:0] cycle;
        logic [31:0] bit_index;
    } sched_entry_t;

    localparam logic [31:0] INJECTOR_IDLE_STATE = 32'hFFFF_FFFF;
    localparam int          ENTRY_W             = $bits(sched_entry_t);

endpackage

// File: rtl/verinject_sched_fifo.sv
// Synchronous FIFO holding the injection schedule; occupancy flags come from registered pointers.
module verinject_sched_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/verinject_injection_sequencer.sv
// Replays queued {cycle, bit_index} entries onto the injector state bus, one
// injection per cycle, while a run is active.
module verinject_injection_sequencer
    import verinject_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter int          TOTAL_BITS = 32,
    parameter logic [31:0] IDLE_STATE = INJECTOR_IDLE_STATE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_cycle,
    input  logic [31:0] cfg_bit,
    input  logic        start,
    input  logic        stop,
    input  logic        flush,
    output logic [31:0] verinject__injector_state,
    output logic        busy,
    output logic        done,
    output logic [15:0] inject_count,
    output logic        err_bad_index
);
    // state   | meaning
    // ST_IDLE | waiting for start; queue may be loaded or flushed
    // ST_RUN  | cycle counter running, due entries popped onto the bus
    // ST_DONE | queue drained; holds until start, stop or flush
    seq_state_e   state;
    logic [31:0]  cycle_cnt;
    sched_entry_t head;
    sched_entry_t cfg_entry;
    logic         full;
    logic         empty;
    logic         accept;
    logic         bad_index;
    logic         push;
    logic         fire;
    logic         fifo_clear;

    assign cfg_ready  = !full;
    assign accept     = cfg_valid && !full;
    assign bad_index  = (cfg_bit >= 32'(TOTAL_BITS));
    assign push       = accept && !bad_index;
    assign fire       = (state == ST_RUN) && !stop && !empty && (head.cycle <= cycle_cnt);
    assign fifo_clear = flush && (state != ST_RUN);
    assign cfg_entry  = '{cycle: cfg_cycle, bit_index: cfg_bit};
    assign busy       = (state == ST_RUN);
    assign done       = (state == ST_DONE);

    verinject_sched_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (fifo_clear),
        .push  (push),
        .pop   (fire),
        .wdata (cfg_entry),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                    <= ST_IDLE;
            cycle_cnt                <= '0;
            inject_count             <= '0;
            err_bad_index            <= 1'b0;
            verinject__injector_state <= IDLE_STATE;
        end else begin
            verinject__injector_state <= fire ? head.bit_index : IDLE_STATE;
            if (fire && inject_count != 16'hFFFF) inject_count <= inject_count + 16'd1;

            // A rejected entry in the same cycle as a flush still leaves the flag set
            if (fifo_clear)           err_bad_index <= 1'b0;
            if (accept && bad_index)  err_bad_index <= 1'b1;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (stop || flush) begin
                        state <= ST_IDLE;
                    end else if (start) begin
                        state        <= empty ? ST_DONE : ST_RUN;
                        cycle_cnt    <= '0;
                        inject_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
                    if (stop)       state <= ST_IDLE;
                    else if (empty) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/verinject_injection_sequencer.md
VERINJECT_INJECTION_SEQUENCER -- requirements
Module: verinject_injection_sequencer

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, number of schedule queue entries (power of 2, >= 2).
REQ-002 Parameters SHALL be: TOTAL_BITS, default 32, number of injectable bit positions in the design (valid bit_index range 0..TOTAL_BITS-1).
REQ-003 Parameters SHALL be: IDLE_STATE, default 32'hFFFF_FFFF, the "no injection" value of the state bus.
REQ-004 Port clock SHALL be an input, 1 bit: the single clock; all state updates on posedge clock.
REQ-005 Port reset SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-006 Port cfg_valid SHALL be an input, 1 bit: a schedule entry is offered.
REQ-007 Port cfg_ready SHALL be an output, 1 bit: the queue can accept an entry.
REQ-008 Port cfg_cycle SHALL be an input, 32 bits: the trigger cycle of the entry.
REQ-009 Port cfg_bit SHALL be an input, 32 bits: the target bit index of the entry.
REQ-010 Port start SHALL be an input, 1 bit: one-cycle pulse that begins a run.
REQ-011 Port stop SHALL be an input, 1 bit: one-cycle pulse that aborts a run.
REQ-012 Port flush SHALL be an input, 1 bit: one-cycle pulse that empties the queue.
REQ-013 Port verinject__injector_state SHALL be an output, 32 bits: registered bus driven to every ff injector.
REQ-014 Port busy SHALL be an output, 1 bit: high while in state RUN.
REQ-015 Port done SHALL be an output, 1 bit: high while in state DONE.
REQ-016 Port inject_count SHALL be an output, 16 bits: number of injections issued since the last start.
REQ-017 Port err_bad_index SHALL be an output, 1 bit: sticky flag, set when an entry with an out-of-range index is rejected.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DONE.
REQ-019 IDLE SHALL go to RUN on start when the queue is not empty; start with an empty queue SHALL go to DONE. Either way, cycle_cnt and inject_count SHALL be cleared to 0.
REQ-020 In RUN, cycle_cnt SHALL increment by 1 every cycle and saturate at 32'hFFFF_FFFF.
REQ-021 In RUN, when the queue is non-empty and head.cycle <= cycle_cnt:
  - the head SHALL be popped;
  - verinject__injector_state SHALL equal head.bit on the next cycle, for exactly one cycle;
  - inject_count SHALL increment, saturating at 16'hFFFF.
REQ-022 At most one injection SHALL occur per cycle. Entries that are late or share a trigger cycle SHALL fire on consecutive cycles, in queue order.
REQ-023 In every cycle without an injection, verinject__injector_state SHALL equal IDLE_STATE.
REQ-024 RUN SHALL go to DONE in the cycle after the last pop empties the queue. DONE SHALL persist until start (go to RUN/DONE per REQ-019) or flush (go to IDLE).
REQ-025 A stop in RUN or DONE SHALL go to IDLE. The queue contents SHALL be retained, and the state bus SHALL return to IDLE_STATE on the next cycle.
REQ-026 Priority SHALL be stop > start. A simultaneous start and stop SHALL result in IDLE.
REQ-027 cfg_ready SHALL equal !full, computed from registered occupancy.
REQ-028 An entry SHALL be accepted on cfg_valid && cfg_ready, in any state.
REQ-029 A pop and a push in the same cycle SHALL both take effect; occupancy stays unchanged.
REQ-030 An entry with cfg_bit >= TOTAL_BITS SHALL be consumed (handshake completes) but SHALL NOT be stored, and SHALL set err_bad_index.
REQ-031 flush SHALL empty the queue and clear err_bad_index in IDLE and DONE; flush SHALL be ignored in RUN.
REQ-032 Entry ordering SHALL be the loader's responsibility: the queue is FIFO, and no sorting is performed.

Reset
REQ-033 On reset:
  - state = IDLE, queue empty, cycle_cnt = 0;
  - inject_count = 0, err_bad_index = 0;
  - verinject__injector_state = IDLE_STATE, busy = 0, done = 0;
  - cfg_ready SHALL be 1 after reset deasserts.
REQ-034 Reset asserted mid-run SHALL force the reset values of REQ-033 immediately and discard the queue.

Structure
REQ-035 A shared package verinject_pkg SHALL hold:
  - the FSM state enum;
  - the schedule-entry struct {cycle[31:0], bit[31:0]};
  - the INJECTOR_IDLE_STATE constant.
REQ-036 The queue SHALL be one sub-module, verinject_sched_fifo, a synchronous FIFO parameterised by DEPTH and entry width, with push/pop/full/empty outputs.

Verification
REQ-037 Load {5,3}, start at t0 -> state bus = 3 for exactly one cycle, 6 cycles after start; inject_count = 1; done asserted the following cycle.
REQ-038 Load {2,0},{2,1},{2,7} -> state bus shows 0, 1, 7 on three consecutive cycles, then IDLE_STATE; inject_count = 3.
REQ-039 Load DEPTH entries -> cfg_ready = 0. During RUN, pop once while cfg_valid is held -> the push is accepted in the pop cycle's successor and occupancy returns to DEPTH.
REQ-040 Load {0,40} with TOTAL_BITS = 32 -> entry is dropped, err_bad_index = 1, start leads to DONE, inject_count = 0. Flush then clears err_bad_index.
REQ-041 Load {100,4}, start, stop at cycle 10 -> IDLE, the entry remains queued, the state bus never leaves IDLE_STATE.
REQ-042 Assert reset mid-run with 2 entries queued -> all outputs at reset values in the same cycle; after release, start leads to DONE with no injection.
